// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES memory path: loader entry layout and slot phase.
package nes_mem_pkg;

  localparam int NES_ADDR_BITS      = 22;
  localparam int NES_CE_SLOT_LOADER = 3;

  // One buffered loader write: byte address plus data byte.
  typedef struct packed {
    logic [NES_ADDR_BITS-1:0] addr;
    logic [7:0]               data;
  } ld_entry_t;

endpackage

// File: rtl/loader_sdram_bridge_if.sv
// Loader write strobe in, SDRAM port-A write out.
interface loader_sdram_bridge_if
  import nes_mem_pkg::*;
#(
  parameter int C_ADDR_BITS = NES_ADDR_BITS
);
  logic                   ld_wr;
  logic [C_ADDR_BITS-1:0] ld_addr;
  logic [7:0]             ld_data;
  logic                   mem_we;
  logic [C_ADDR_BITS-1:0] mem_addr;
  logic [7:0]             mem_din;

  // The bridge consumes loader writes and drives the SDRAM port.
  modport slave (
    input  ld_wr, ld_addr, ld_data,
    output mem_we, mem_addr, mem_din
  );

  // The loader side / environment drives strobes and observes the port.
  modport master (
    output ld_wr, ld_addr, ld_data,
    input  mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: registered write, asynchronous read of the head entry.
module sync_fifo_ram #(
  parameter int WIDTH      = 30,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/loader_sdram_bridge.sv
// Rate-matching write buffer: loader bytes arrive at any rate and are replayed
// to SDRAM port A one per NES slot, each write held for the full 4-clk slot.
module loader_sdram_bridge
  import nes_mem_pkg::*;
#(
  parameter int C_DEPTH_LOG2 = 3,
  parameter int C_SLOT       = NES_CE_SLOT_LOADER,
  parameter int C_ADDR_BITS  = NES_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [1:0]            nes_ce,
  loader_sdram_bridge_if.slave  bus,
  output logic [C_DEPTH_LOG2:0] level,
  output logic                  overflow,
  output logic                  idle
);

  localparam int W = C_ADDR_BITS + 8;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [C_DEPTH_LOG2:0]   wptr;
  logic [C_DEPTH_LOG2:0]   rptr;
  logic [W-1:0]            head;
  logic                    full;
  logic                    empty;
  logic                    slot;
  logic                    pop;
  logic                    push;
  logic                    mem_we_q;
  logic [C_ADDR_BITS-1:0]  mem_addr_q;
  logic [7:0]              mem_din_q;

  assign empty = (wptr == rptr);
  assign full  = (wptr[C_DEPTH_LOG2] != rptr[C_DEPTH_LOG2]) &&
                 (wptr[C_DEPTH_LOG2-1:0] == rptr[C_DEPTH_LOG2-1:0]);
  assign slot  = (nes_ce == 2'(C_SLOT));
  assign pop   = slot && !empty;
  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign push  = bus.ld_wr && (!full || pop);

  sync_fifo_ram #(
    .WIDTH      (W),
    .DEPTH_LOG2 (C_DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[C_DEPTH_LOG2-1:0]),
    .wdata ({bus.ld_addr, bus.ld_data}),
    .raddr (rptr[C_DEPTH_LOG2-1:0]),
    .rdata (head)
  );

  // Pointer, overflow and slot-output update; flush overrides push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (bus.ld_wr && !push) overflow <= 1'b1;
      if (slot) begin
        if (!empty) begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= head[W-1:8];
          mem_din_q  <= head[7:0];
          rptr       <= rptr + 1'b1;
        end else begin
          mem_we_q <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign level        = wptr - rptr;
  assign idle         = empty && !mem_we_q;

endmodule

// File: tb/tb_loader_sdram_bridge.sv
// Scoreboard bench: stimulus queues expected SDRAM writes, a negedge monitor
// checks each slot's write against the queue and checks that writes are held.
module tb_loader_sdram_bridge;
  import nes_mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] nes_ce = 2'd0;
  logic [3:0] level;
  logic       overflow;
  logic       idle;

  loader_sdram_bridge_if #(.C_ADDR_BITS(22)) bus ();

  loader_sdram_bridge #(
    .C_DEPTH_LOG2 (3),
    .C_SLOT       (3),
    .C_ADDR_BITS  (22)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .nes_ce   (nes_ce),
    .bus      (bus),
    .level    (level),
    .overflow (overflow),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int        n_tests = 0;
  int        n_fail  = 0;
  ld_entry_t exp_q[$];
  bit        mon_en = 1'b0;
  logic        cur_we;
  logic [21:0] cur_addr;
  logic [7:0]  cur_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; nes_ce advances just after the edge so it is stable for the next one.
  task automatic tick();
    @(posedge clk);
    #1;
    nes_ce = nes_ce + 2'd1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4 && nes_ce != p; i++) tick();
  endtask

  task automatic push(input logic [21:0] a, input logic [7:0] d, input bit accept);
    ld_entry_t e;
    bus.ld_wr   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    if (accept) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    tick();
    bus.ld_wr = 1'b0;
  endtask

  task automatic burst(input int n, input int n_acc, input logic [21:0] a0, input logic [7:0] d0);
    for (int i = 0; i < n; i++)
      push(a0 + 22'(i), d0 + 8'(i), i < n_acc);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && !idle; i++) tick();
    chk({name, "_idle"}, 32'(idle), 32'd1);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_level"}, 32'(level), 32'd0);
  endtask

  // nes_ce reads 0 at a negedge exactly when the preceding edge was a slot edge.
  always @(negedge clk) begin
    ld_entry_t e;
    if (!mon_en || !reset_n) begin
      cur_we   = bus.mem_we;
      cur_addr = bus.mem_addr;
      cur_din  = bus.mem_din;
    end else if (nes_ce == 2'd0) begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.mem_addr), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("slot_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("slot_din", 32'(bus.mem_din), 32'(e.data));
        end
      end
      cur_we   = bus.mem_we;
      cur_addr = bus.mem_addr;
      cur_din  = bus.mem_din;
    end else begin
      chk("hold_we", 32'(bus.mem_we), 32'(cur_we));
      if (cur_we) begin
        chk("hold_addr", 32'(bus.mem_addr), 32'(cur_addr));
        chk("hold_din", 32'(bus.mem_din), 32'(cur_din));
      end
    end
  end

  initial begin
    bus.ld_wr   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;

    // 1: reset values, then idle with nes_ce cycling
    #2;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
    chk("idle_idle", 32'(idle), 32'd1);
    chk("idle_level", 32'(level), 32'd0);

    // 2: single push at phase 0 lands at the phase-3 edge
    wait_phase(2'd0);
    push(22'h000010, 8'hA5, 1'b1);
    chk("single_level", 32'(level), 32'd1);
    chk("single_not_idle", 32'(idle), 32'd0);
    tick(); tick();
    chk("single_we_before_slot", 32'(bus.mem_we), 32'd0);
    tick();
    chk("single_we_at_slot", 32'(bus.mem_we), 32'd1);
    chk("single_addr", 32'(bus.mem_addr), 32'h10);
    chk("single_din", 32'(bus.mem_din), 32'hA5);
    drain("single");

    // 3: 8 consecutive pushes, two slot pops during the burst -> level 6
    wait_phase(2'd0);
    burst(8, 8, 22'h000100, 8'h30);
    chk("burst8_level", 32'(level), 32'd6);
    chk("burst8_overflow", 32'(overflow), 32'd0);
    drain("burst8");

    // 4: 11 pushes from phase 0; FIFO fills on the 10th and the 11th is dropped
    wait_phase(2'd0);
    burst(11, 10, 22'h002000, 8'h40);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears_ovf", 32'(overflow), 32'd0);

    // 5: full FIFO, push on a slot edge is accepted
    wait_phase(2'd0);
    burst(10, 10, 22'h3FFF00, 8'h80);
    tick();
    chk("full_level", 32'(level), 32'd8);
    chk("full_overflow", 32'(overflow), 32'd0);
    push(22'h155555, 8'hEE, 1'b1);
    chk("full_slot_push_level", 32'(level), 32'd8);
    chk("full_slot_push_ovf", 32'(overflow), 32'd0);
    drain("full_slot");

    // 6: flush with a write in flight and level 5
    wait_phase(2'd0);
    burst(6, 6, 22'h000200, 8'h11);
    chk("preflush_level", 32'(level), 32'd5);
    chk("preflush_we", 32'(bus.mem_we), 32'd1);
    mon_en = 1'b0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    exp_q.delete();
    chk("flush_we", 32'(bus.mem_we), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_idle", 32'(idle), 32'd1);

    // reset pulse in the middle of a slot drops the outputs immediately
    wait_phase(2'd0);
    push(22'h3A5A5, 8'h5C, 1'b0);
    tick(); tick(); tick();
    chk("midslot_we", 32'(bus.mem_we), 32'd1);
    chk("midslot_addr", 32'(bus.mem_addr), 32'h3A5A5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(bus.mem_we), 32'd0);
    chk("async_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("async_rst_din", 32'(bus.mem_din), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_idle", 32'(idle), 32'd1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_we", 32'(bus.mem_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
